// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS memory stage.
package mips_pkg;

    localparam int ADDR_W = 32;
    localparam logic [31:0] DMEM_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } dmem_state_t;

endpackage

// File: rtl/dmem_wait_timer.sv
// Counts WAIT cycles without an ack; flags the last allowed WAIT cycle.
module dmem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_count;

    // expired marks the TIMEOUT-th WAIT cycle, so the abort lands on time
    assign expired = (r_count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access sequencer: issues req/ack accesses, stalls the
// pipeline while one is outstanding, reports misalign and timeout errors.
module dmem_ctrl
    import mips_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = DMEM_ERR_DATA
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_m,
    input  logic              mem_write_m,
    input  logic [ADDR_W-1:0] alu_out_m,
    input  logic [31:0]       write_data_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic [31:0]       read_data_m,
    output logic              addr_err,
    output logic              bus_err,
    output logic [31:0]       stall_count
);

    dmem_state_t       r_state;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_addr_err;
    logic              r_bus_err;
    logic [31:0]       r_stall_count;

    logic w_access;
    logic w_aligned;
    logic w_stall;
    logic w_expired;
    logic w_tmr_clear;
    logic w_tmr_en;

    assign w_access    = mem_read_m | mem_write_m;
    assign w_aligned   = (alu_out_m[1:0] == 2'b00);
    assign w_tmr_clear = (r_state == IDLE);
    assign w_tmr_en    = (r_state == WAIT) && !mem_ack;

    always_comb begin
        w_stall = 1'b0;
        if (r_state == WAIT) begin
            w_stall = 1'b1;
        end else if (r_state == IDLE) begin
            w_stall = w_access && w_aligned;
        end
    end

    dmem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_tmr_clear),
        .enable (w_tmr_en),
        .expired(w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_addr_err    <= 1'b0;
            r_bus_err     <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_addr_err <= 1'b0;
            r_bus_err  <= 1'b0;
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_access && w_aligned) begin
                        r_addr  <= alu_out_m;
                        r_wdata <= write_data_m;
                        r_we    <= mem_write_m;
                        r_req   <= 1'b1;
                        r_state <= WAIT;
                    end else if (w_access) begin
                        r_addr_err <= 1'b1;
                    end
                end
                WAIT: begin
                    // ack beats a simultaneous timeout
                    if (mem_ack) begin
                        if (!r_we) begin
                            r_rdata <= mem_rdata;
                        end
                        r_req   <= 1'b0;
                        r_state <= DONE;
                    end else if (w_expired) begin
                        if (!r_we) begin
                            r_rdata <= ERR_DATA;
                        end
                        r_bus_err <= 1'b1;
                        r_req     <= 1'b0;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req     = r_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign stall       = w_stall;
    assign read_data_m = r_rdata;
    assign addr_err    = r_addr_err;
    assign bus_err     = r_bus_err;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a request/readback scoreboard.
module tb_dmem_ctrl;
    import mips_pkg::*;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic        mem_read_m;
    logic        mem_write_m;
    logic [31:0] alu_out_m;
    logic [31:0] write_data_m;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic [31:0] read_data_m;
    logic        addr_err;
    logic        bus_err;
    logic [31:0] stall_count;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        berr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks;
    int          failures;
    logic [31:0] m_rd;
    logic [31:0] m_cnt;
    int          n_req;
    logic        prev_req;

    dmem_ctrl #(
        .TIMEOUT (TMO),
        .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read_m  (mem_read_m),
        .mem_write_m (mem_write_m),
        .alu_out_m   (alu_out_m),
        .write_data_m(write_data_m),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .stall       (stall),
        .read_data_m (read_data_m),
        .addr_err    (addr_err),
        .bus_err     (bus_err),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req && !prev_req) begin
            n_req <= n_req + 1;
        end
        prev_req <= mem_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // nwait = WAIT cycles including the ack cycle; ack=0 means timeout
    task automatic access(input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int nwait,
                          input bit ack, input bit last);
        exp_t e;
        exp_t got;
        e.we    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        if (!wr) m_rd = ack ? rdata : 32'hDEADBEEF;
        e.rd   = m_rd;
        e.berr = !ack;
        exp_q.push_back(e);
        got = '{we: 1'b0, addr: '0, wdata: '0, rd: '0, berr: 1'b0};

        @(negedge clk);
        mem_read_m   = rd;
        mem_write_m  = wr;
        alu_out_m    = addr;
        write_data_m = wdata;
        mem_ack      = 1'b0;
        #1;
        chk1("idle_stall", stall, 1'b1);
        chk1("idle_req", mem_req, 1'b0);
        m_cnt = m_cnt + 32'(nwait + 1);

        for (int k = 0; k < nwait; k++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            if (k == 0) begin
                chk1("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) got = exp_q.pop_front();
            end
            chk1("wait_req", mem_req, 1'b1);
            chk1("wait_stall", stall, 1'b1);
            chk1("wait_we", mem_we, got.we);
            chk("wait_addr", mem_addr, got.addr);
            chk("wait_wdata", mem_wdata, got.wdata);
            if (ack && k == nwait - 1) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
        end

        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0BAD0BAD;
        #1;
        chk1("done_stall", stall, 1'b0);
        chk1("done_req", mem_req, 1'b0);
        chk("done_rdata", read_data_m, got.rd);
        chk1("done_bus_err", bus_err, got.berr);
        chk("done_stall_count", stall_count, m_cnt);

        if (last) begin
            @(negedge clk);
            mem_read_m  = 1'b0;
            mem_write_m = 1'b0;
            #1;
            chk1("post_stall", stall, 1'b0);
            chk1("post_bus_err", bus_err, 1'b0);
            chk1("post_req", mem_req, 1'b0);
        end
    endtask

    initial begin
        int base;
        checks       = 0;
        failures     = 0;
        m_rd         = '0;
        m_cnt        = '0;
        n_req        = 0;
        prev_req     = 1'b0;
        rst_n        = 1'b0;
        mem_read_m   = 1'b0;
        mem_write_m  = 1'b0;
        alu_out_m    = '0;
        write_data_m = '0;
        mem_rdata    = '0;
        mem_ack      = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk1("rst_req", mem_req, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk("rst_rdata", read_data_m, 32'h0);
        chk("rst_count", stall_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // load, ack in first WAIT cycle
        access(1'b1, 1'b0, 32'h100, 32'h0, 32'h12345678, 1, 1'b1, 1'b1);
        // store, ack after 3 WAIT cycles
        access(1'b0, 1'b1, 32'h204, 32'hCAFEF00D, 32'h0, 3, 1'b1, 1'b1);

        // misaligned load
        @(negedge clk);
        mem_read_m = 1'b1;
        alu_out_m  = 32'h102;
        #1;
        chk1("mis_stall", stall, 1'b0);
        chk1("mis_req", mem_req, 1'b0);
        @(negedge clk);
        mem_read_m = 1'b0;
        #1;
        chk1("mis_addr_err", addr_err, 1'b1);
        chk1("mis_req2", mem_req, 1'b0);
        chk("mis_rdata", read_data_m, m_rd);
        @(negedge clk);
        #1;
        chk1("mis_addr_err_off", addr_err, 1'b0);

        // stray ack in IDLE is ignored
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("stray_ack_rdata", read_data_m, m_rd);
        chk1("stray_ack_req", mem_req, 1'b0);

        // timeout on a load
        access(1'b1, 1'b0, 32'h300, 32'h0, 32'h0, TMO, 1'b0, 1'b1);
        // ack on the last allowed WAIT cycle wins over timeout
        access(1'b1, 1'b0, 32'h304, 32'h0, 32'hA5A5A5A5, TMO, 1'b1, 1'b1);

        // back-to-back loads
        base = n_req;
        access(1'b1, 1'b0, 32'h400, 32'h0, 32'h11111111, 1, 1'b1, 1'b0);
        access(1'b1, 1'b0, 32'h404, 32'h0, 32'h22222222, 1, 1'b1, 1'b1);
        chk("b2b_req_count", 32'(n_req - base), 32'd2);

        // read+write together acts as a write
        access(1'b1, 1'b1, 32'h500, 32'h0F0F0F0F, 32'h77777777, 1, 1'b1, 1'b1);

        // reset during WAIT
        @(negedge clk);
        mem_read_m = 1'b1;
        alu_out_m  = 32'h600;
        @(negedge clk);
        #1;
        chk1("rw_req_before", mem_req, 1'b1);
        #2;
        rst_n      = 1'b0;
        mem_read_m = 1'b0;
        #1;
        chk1("rw_req", mem_req, 1'b0);
        chk1("rw_we", mem_we, 1'b0);
        chk("rw_addr", mem_addr, 32'h0);
        chk("rw_wdata", mem_wdata, 32'h0);
        chk("rw_rdata", read_data_m, 32'h0);
        chk("rw_count", stall_count, 32'h0);
        chk1("rw_stall", stall, 1'b0);
        chk1("rw_bus_err", bus_err, 1'b0);
        m_rd  = '0;
        m_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;

        access(1'b1, 1'b0, 32'h700, 32'h0, 32'h89ABCDEF, 2, 1'b1, 1'b1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access sequencer for the MIPS pipeline memory stage. Sits between the M-stage pipeline register outputs (MemtoReg, MemWrite, ALU result, write data) and a variable-latency data memory with a req/ack handshake. It freezes the pipeline while an access is outstanding, captures load data for writeback, and reports misaligned-address and bus-timeout errors.

## Interface
- `TIMEOUT`, default 16: maximum WAIT cycles before an access is aborted with a bus error (≥1).
- `ERR_DATA`, default 32'hDEADBEEF: load data returned on timeout.
- `clk` input 1: pipeline clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `mem_read_m` input 1: M-stage MemtoReg (load in M).
- `mem_write_m` input 1: M-stage MemWrite (store in M).
- `alu_out_m` input 32: M-stage effective address.
- `write_data_m` input 32: M-stage store data.
- `mem_req` output 1: request to memory.
- `mem_we` output 1: 1 = write, 0 = read.
- `mem_addr` output 32: word address, registered.
- `mem_wdata` output 32: store data, registered.
- `mem_rdata` input 32: load data, valid when `mem_ack`=1.
- `mem_ack` input 1: memory completion, one-cycle pulse.
- `stall` output 1: freeze the F/D/E/M pipeline registers.
- `read_data_m` output 32: captured load data for the M→W register.
- `addr_err` output 1: one-cycle pulse, misaligned access dropped.
- `bus_err` output 1: one-cycle pulse, access timed out.
- `stall_count` output 32: saturating count of stalled cycles.

## Operation
- `access` = `mem_read_m` | `mem_write_m`. `aligned` = (`alu_out_m[1:0]` == 0).
- The FSM has three states: IDLE, WAIT, DONE.
- IDLE:
  - If `access` & `aligned`: latch `mem_addr` ← `alu_out_m`, `mem_wdata` ← `write_data_m`, `mem_we` ← `mem_write_m`, clear the timer, go to WAIT. `stall`=1 in this cycle (combinational).
  - If `access` & !`aligned`: no request is issued. Pulse `addr_err` next cycle. Stay in IDLE with `stall`=0. The instruction proceeds and `read_data_m` is unchanged.
  - If both `mem_read_m` and `mem_write_m` are set, the access is a write.
- WAIT:
  - `mem_req`=1 and `stall`=1. Address, data and we stay stable until ack.
  - On `mem_ack`: if read, `read_data_m` ← `mem_rdata`. Go to DONE.
  - Otherwise the timer increments. When it reaches `TIMEOUT` with no ack: drop `mem_req`, pulse `bus_err`, load `read_data_m` ← `ERR_DATA` (reads only), go to DONE.
  - An ack arriving in the same cycle as the timeout wins; no `bus_err`.
- DONE:
  - `stall`=0 and `mem_req`=0. The M register advances at the end of this cycle.
  - Always returns to IDLE. This prevents re-issuing the completed instruction.
- `stall_count` increments every cycle `stall`=1 and saturates at 32'hFFFFFFFF.
- A `mem_ack` seen outside WAIT is ignored.

## Timing
- Reset values: state IDLE, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `read_data_m` 0, `addr_err` 0, `bus_err` 0, `stall_count` 0, timer 0. `stall` = 0 in IDLE with no access.
- Reset asserted mid-access: `mem_req` drops immediately (asynchronously) and the FSM returns to IDLE. The memory must tolerate an abandoned request.
- Minimum access (ack in first WAIT cycle): cycle 0 IDLE (stall), cycle 1 WAIT (req, ack), cycle 2 DONE. That is 2 stall cycles, and `read_data_m` is valid from cycle 2.
- An ack after N WAIT cycles gives N+1 stall cycles.
- Timeout: `bus_err` is high during the DONE cycle. Total stall is `TIMEOUT`+1 cycles.
- `addr_err` is high the cycle after the misaligned instruction is in M.
- Back-to-back accesses: the next access in M is detected in IDLE the cycle after DONE. There is no overlap.

## Structure
- Shared package `mips_pkg`:
  - state enum `dmem_state_t` {IDLE, WAIT, DONE};
  - constant `DMEM_ERR_DATA`;
  - width constant `ADDR_W` = 32.
- Sub-module `dmem_wait_timer`:
  - `clear`/`enable` inputs, `expired` output, parameterized by `TIMEOUT`;
  - same `clk`/`rst_n` as the parent.
- The FSM, data latches and the stall counter live in `dmem_ctrl`.

## Test plan
- Load, addr 0x100, ack in first WAIT cycle with rdata 0x12345678 → `stall` high 2 cycles, `mem_we`=0, `read_data_m`=0x12345678 in DONE, `stall_count`=2.
- Store, addr 0x204, data 0xCAFEF00D, ack after 3 WAIT cycles → `mem_we`=1 with addr and data stable for 3 cycles, 4 stall cycles, `read_data_m` unchanged.
- Load at addr 0x102 → no `mem_req`, `stall`=0, `addr_err` pulses once the next cycle.
- Load with `TIMEOUT`=4 and no ack → `mem_req` for 4 cycles, then `bus_err` pulse, `read_data_m`=0xDEADBEEF, FSM back in IDLE.
- Two consecutive loads (ack immediate each) → two separate requests separated by the DONE cycle, with no duplicate request for the first load.
- `rst_n` low during WAIT → `mem_req` 0 immediately, all outputs at reset values. After release, a new load completes normally.
